// File: rtl/sr_trace_monitor_pkg.sv
// Shared definitions for the schoolRISCV trace monitor.
//   - srtmState_t : monitor state encoding as seen on the `state` port
//   - *_LSB       : bit offsets of the fields inside one packed trace entry
//                   {cycle, pc, instr, wreg}, wreg in the least significant bits
package sr_trace_monitor_pkg;

  typedef enum logic [1:0] {
    SRTM_IDLE    = 2'd0,
    SRTM_RUN     = 2'd1,
    SRTM_HALTED  = 2'd2,
    SRTM_TIMEOUT = 2'd3
  } srtmState_t;

  localparam int WREG_LSB  = 0;
  localparam int INSTR_LSB = 32;
  localparam int PC_LSB    = 64;
  localparam int CYCLE_LSB = 96;

endpackage

// File: rtl/sr_trace_fifo.sv
// Synchronous trace FIFO with a registered read port and a synchronous flush.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : empties the FIFO and drops rdValid; wins over push/pop
//   push        : write pushData this cycle
//   pushData    : entry to store
//   pop         : read one entry; ignored while empty
//   rdValid     : one-cycle strobe, rdData updated from an accepted pop
//   rdData      : last popped entry, held until the next pop
//   count       : entries stored
//   pushDropped : push was refused because the FIFO was full
module sr_trace_fifo #(
  parameter int WIDTH = 112,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic                     rdValid,
  output logic [WIDTH-1:0]         rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pushDropped
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             full;
  logic             popOk;
  logic             pushOk;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign popOk = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still fits.
  assign pushOk      = push && (!full || popOk);
  assign pushDropped = push && !pushOk;
  assign count       = wrPtr - rdPtr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      rdValid <= 1'b0;
      rdData  <= '0;
    end else if (flush) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      rdValid <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk) begin
        rdPtr  <= rdPtr + 1'b1;
        rdData <= mem[rdPtr[AW-1:0]];
      end
      rdValid <= popOk;
    end
  end

  // Storage array: data only, no reset.
  always_ff @(posedge clk) begin
    if (pushOk && !flush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/sr_trace_monitor.sv
// Execution-trace monitor for the schoolRISCV core.
// Samples {cycle, pc, instr, wreg} on every `step` while running, detects a
// self-loop halt (pc unchanged for HALT_REPEAT samples) or a sample-count
// timeout, and buffers samples in a FIFO for host readout.
// Ports:
//   clk, rst_n            : CPU clock, asynchronous active-low reset
//   start                 : IDLE -> RUN
//   clear                 : back to IDLE, flush FIFO, counters and overflow
//   step                  : CPU advanced this cycle (sample strobe)
//   pc, instr, wreg       : sampled CPU values
//   rd_en                 : pop one entry
//   rd_valid              : popped data valid (one cycle after accepted pop)
//   rd_cycle/pc/instr/wreg: popped entry fields
//   count                 : entries stored
//   state                 : IDLE=0 RUN=1 HALTED=2 TIMEOUT=3
//   overflow              : sticky, a sample was dropped on a full FIFO
module sr_trace_monitor
  import sr_trace_monitor_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 120,
  parameter int HALT_REPEAT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   step,
  input  logic [31:0]            pc,
  input  logic [31:0]            instr,
  input  logic [31:0]            wreg,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [CNT_W-1:0]       rd_cycle,
  output logic [31:0]            rd_pc,
  output logic [31:0]            rd_instr,
  output logic [31:0]            rd_wreg,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             state,
  output logic                   overflow
);

  localparam int ENTRY_W = CNT_W + 96;
  localparam int REP_W   = $clog2(HALT_REPEAT + 1);

  srtmState_t       stateQ;
  srtmState_t       stateNext;
  logic [CNT_W-1:0] cycleQ;
  logic [REP_W-1:0] repQ;
  logic [REP_W-1:0] repNext;
  logic [31:0]      prevPc;
  logic             overflowQ;
  logic             sample;
  logic             haltHit;
  logic             timeoutHit;
  logic             pushDropped;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] rdData;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= SRTM_IDLE;
    else        stateQ <= stateNext;
  end

  // FSM next state
  always_comb begin
    stateNext = stateQ;
    if (clear) begin
      stateNext = SRTM_IDLE;
    end else begin
      case (stateQ)
        SRTM_IDLE: if (start) stateNext = SRTM_RUN;
        SRTM_RUN: begin
          // Halt takes precedence when both fire on the same sample.
          if (haltHit)         stateNext = SRTM_HALTED;
          else if (timeoutHit) stateNext = SRTM_TIMEOUT;
        end
        default: stateNext = stateQ;
      endcase
    end
  end

  // FSM outputs and sample decode
  always_comb begin
    sample     = (stateQ == SRTM_RUN) && step && !clear;
    // repQ == 0 marks "no previous sample", so the first sample counts as 1.
    repNext    = ((repQ != '0) && (pc == prevPc)) ? repQ + REP_W'(1) : REP_W'(1);
    haltHit    = sample && (repNext == REP_W'(HALT_REPEAT));
    timeoutHit = sample && (cycleQ == CNT_W'(TIMEOUT - 1));
  end

  // Sample bookkeeping: cycle number, repeat run length, sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleQ    <= '0;
      repQ      <= '0;
      overflowQ <= 1'b0;
    end else if (clear) begin
      cycleQ    <= '0;
      repQ      <= '0;
      overflowQ <= 1'b0;
    end else if (sample) begin
      // Terminal states stop sampling at TIMEOUT-1, so this never wraps.
      cycleQ <= cycleQ + CNT_W'(1);
      repQ   <= repNext;
      if (pushDropped) overflowQ <= 1'b1;
    end
  end

  // Previous-sample pc is only meaningful while repQ != 0; no reset needed.
  always_ff @(posedge clk) begin
    if (sample) prevPc <= pc;
  end

  assign entry = {cycleQ, pc, instr, wreg};

  sr_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (clear),
    .push        (sample),
    .pushData    (entry),
    .pop         (rd_en),
    .rdValid     (rd_valid),
    .rdData      (rdData),
    .count       (count),
    .pushDropped (pushDropped)
  );

  assign rd_cycle = rdData[CYCLE_LSB +: CNT_W];
  assign rd_pc    = rdData[PC_LSB    +: 32];
  assign rd_instr = rdData[INSTR_LSB +: 32];
  assign rd_wreg  = rdData[WREG_LSB  +: 32];
  assign state    = stateQ;
  assign overflow = overflowQ;

endmodule

// File: tb/tb_sr_trace_monitor.sv
module tb_sr_trace_monitor;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int TMO   = 8;
  localparam int HR    = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start, clear, step, rd_en;
  logic [31:0]            pc, instr, wreg;
  logic                   rd_valid;
  logic [CNT_W-1:0]       rd_cycle;
  logic [31:0]            rd_pc, rd_instr, rd_wreg;
  logic [$clog2(DEPTH):0] count;
  logic [1:0]             state;
  logic                   overflow;

  always #5 clk = ~clk;

  sr_trace_monitor #(
    .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TMO), .HALT_REPEAT(HR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .step(step),
    .pc(pc), .instr(instr), .wreg(wreg), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_cycle(rd_cycle), .rd_pc(rd_pc),
    .rd_instr(rd_instr), .rd_wreg(rd_wreg), .count(count),
    .state(state), .overflow(overflow)
  );

  // Reference model: trace as a queue of entries, halt judged from the pc history.
  typedef struct {
    int unsigned cyc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wreg;
  } entry_t;

  entry_t      q[$];
  logic [31:0] hist[$];
  int          mState;
  int unsigned mCyc;
  bit          mOvf;
  bit          mRdValid;
  entry_t      mRd;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    hist.delete();
    mState = 0;
    mCyc = 0;
    mOvf = 0;
    mRdValid = 0;
    mRd = '{0, 32'h0, 32'h0, 32'h0};
  endtask

  task automatic modelClock();
    entry_t e;
    entry_t popped;
    bit popOk, halt, tout;
    int sz, pre;
    if (clear) begin
      q.delete();
      hist.delete();
      mState = 0;
      mCyc = 0;
      mOvf = 0;
      mRdValid = 0;
      return;
    end
    pre   = mState;
    sz    = q.size();
    popOk = rd_en && (sz > 0);
    if (popOk) begin
      popped = q[0];
      void'(q.pop_front());
    end
    if (pre == 1 && step) begin
      e.cyc = mCyc; e.pc = pc; e.instr = instr; e.wreg = wreg;
      if (sz < DEPTH || popOk) q.push_back(e);
      else mOvf = 1;
      hist.push_back(pc);
      halt = (hist.size() >= HR);
      for (int k = 1; k < HR; k++)
        if (halt && hist[hist.size() - 1 - k] != pc) halt = 0;
      tout = (mCyc == TMO - 1);
      mCyc++;
      if (halt) mState = 2;
      else if (tout) mState = 3;
    end
    if (pre == 0 && start) mState = 1;
    mRdValid = popOk;
    if (popOk) mRd = popped;
  endtask

  task automatic checkAll();
    chk("count",    64'(count),    64'(q.size()));
    chk("state",    64'(state),    64'(mState));
    chk("overflow", 64'(overflow), 64'(mOvf));
    chk("rd_valid", 64'(rd_valid), 64'(mRdValid));
    chk("rd_cycle", 64'(rd_cycle), 64'(mRd.cyc % (1 << CNT_W)));
    chk("rd_pc",    64'(rd_pc),    64'(mRd.pc));
    chk("rd_instr", 64'(rd_instr), 64'(mRd.instr));
    chk("rd_wreg",  64'(rd_wreg),  64'(mRd.wreg));
  endtask

  // One clock: drive inputs away from the edge, advance model, sample after edge.
  task automatic tick(input bit iStart, input bit iClear, input bit iStep,
                      input bit iRd, input logic [31:0] iPc);
    start = iStart; clear = iClear; step = iStep; rd_en = iRd; pc = iPc;
    instr = $urandom; wreg = $urandom;
    modelClock();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  int loopPcs[6]    = '{0, 4, 8, 8, 8, 8};
  int tiePcs[8]     = '{0, 4, 8, 12, 16, 20, 20, 20};
  logic [31:0] rpc;

  initial begin
    rst_n = 1'b0;
    start = 0; clear = 0; step = 0; rd_en = 0;
    pc = '0; instr = '0; wreg = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    rst_n = 1'b1;

    // Loop halt with reads keeping the FIFO from filling
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 1, (i >= 2), loopPcs[i]);
    chk("halted_state", 64'(state), 64'(2));
    tick(0, 0, 1, 0, 32'h40);
    tick(1, 0, 1, 0, 32'h44);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 0);

    // Clear beats start and step
    tick(0, 0, 1, 0, 0);
    tick(1, 1, 1, 1, 0);
    chk("clear_idle", 64'(state), 64'(0));

    // Overflow: six samples, no reads, then drain
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 1, 0, 32'(i * 4));
    chk("ovf_flag", 64'(overflow), 64'(1));
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 0);

    // Full push plus pop in one cycle
    tick(0, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 32'(16 + i * 4));
    tick(0, 0, 1, 1, 32'h80);
    chk("fullpp_ovf", 64'(overflow), 64'(0));
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 0);

    // Timeout with continuous reads, then ignored steps
    tick(0, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < TMO; i++) tick(0, 0, 1, 1, 32'(i * 4));
    chk("timeout_state", 64'(state), 64'(3));
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 1, 32'h200);

    // Halt and timeout on the same sample
    tick(0, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < TMO; i++) tick(0, 0, 1, 1, tiePcs[i]);
    chk("tie_state", 64'(state), 64'(2));

    // Asynchronous reset in the middle of a run
    tick(0, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, (i == 2), 32'h100 + 32'(i * 4));
    rst_n = 1'b0;
    #2;
    chk("arst_state",    64'(state),    64'(0));
    chk("arst_count",    64'(count),    64'(0));
    chk("arst_overflow", 64'(overflow), 64'(0));
    chk("arst_rd_valid", 64'(rd_valid), 64'(0));
    chk("arst_rd_pc",    64'(rd_pc),    64'(0));
    chk("arst_rd_cycle", 64'(rd_cycle), 64'(0));
    modelReset();
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rpc = 32'($urandom_range(0, 2) * 4);
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
